// File: rtl/pc_pkg.sv
// Shared program-counter definitions: next-PC source select encodings used by
// both the control unit and the PC unit.
package pc_pkg;

    localparam int unsigned PC_SEL_W = 2;

    typedef enum logic [PC_SEL_W-1:0] {
        PC_SEL_SEQ    = 2'd0,
        PC_SEL_BRANCH = 2'd1,
        PC_SEL_JUMP   = 2'd2,
        PC_SEL_JREG   = 2'd3
    } pc_sel_e;

endpackage

// File: rtl/pc_ras.sv
// Return-address stack: circular LIFO of link addresses with a saturating
// valid-entry count and sticky overflow/underflow flags. When full, a push
// silently overwrites the oldest entry because the pointer simply wraps.
module pc_ras #(
    parameter  int unsigned XLEN      = 32,
    parameter  int unsigned RAS_DEPTH = 4,
    localparam int unsigned PTR_W     = $clog2(RAS_DEPTH),
    localparam int unsigned CNT_W     = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             unf_req,
    input  logic [XLEN-1:0]  push_data,
    output logic [XLEN-1:0]  top,
    output logic [CNT_W-1:0] count,
    output logic             ovf,
    output logic             unf
);

    logic [XLEN-1:0]  entry_q [RAS_DEPTH];
    logic [XLEN-1:0]  entry_d [RAS_DEPTH];
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic [PTR_W-1:0] top_idx;
    logic             full;

    assign top_idx = ptr_q - PTR_W'(1);
    assign full    = (count_q == CNT_W'(RAS_DEPTH));

    // Stack update: a simultaneous push and pop replaces the top in place.
    always_comb begin
        entry_d = entry_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q | unf_req;
        if (push && pop) begin
            entry_d[top_idx] = push_data;
        end else if (push) begin
            entry_d[ptr_q] = push_data;
            ptr_d          = ptr_q + PTR_W'(1);
            if (full) begin
                ovf_d = 1'b1;
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end else if (pop) begin
            ptr_d   = top_idx;
            count_d = count_q - CNT_W'(1);
        end
    end

    // Stack state registers; flags are sticky until reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            entry_q <= '{default: '0};
            ptr_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            entry_q <= entry_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign top   = entry_q[top_idx];
    assign count = count_q;
    assign ovf   = ovf_q;
    assign unf   = unf_q;

endmodule

// File: rtl/pc_ctrl.sv
// Program-counter unit: PC register, increment and branch adders, next-PC
// select and a return-address stack for call/return prediction.
module pc_ctrl
    import pc_pkg::*;
#(
    parameter  int unsigned     XLEN      = 32,
    parameter  int unsigned     PC_STEP   = 1,
    parameter  int unsigned     OFF_SHIFT = 0,
    parameter  logic [XLEN-1:0] RESET_VEC = '0,
    parameter  int unsigned     RAS_DEPTH = 4,
    localparam int unsigned     CNT_W     = $clog2(RAS_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic [1:0]       pc_sel,
    input  logic             branch_taken,
    input  logic [XLEN-1:0]  pc_offset,
    input  logic [XLEN-1:0]  pc_jmp,
    input  logic [XLEN-1:0]  pc_jr,
    input  logic             call,
    input  logic             ret,
    output logic [XLEN-1:0]  pc,
    output logic [XLEN-1:0]  pc_next,
    output logic [CNT_W-1:0] ras_count,
    output logic             ras_mismatch,
    output logic             err_ovf,
    output logic             err_unf
);

    pc_sel_e          sel;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic [XLEN-1:0]  pc_inc;
    logic [XLEN-1:0]  off_shifted;
    logic [XLEN-1:0]  br_target;
    logic [XLEN-1:0]  ras_top;
    logic [CNT_W-1:0] ras_cnt;
    logic             ras_nonempty;
    logic             is_jreg;
    logic             ras_push;
    logic             ras_pop;
    logic             ras_unf_req;

    assign sel          = pc_sel_e'(pc_sel);
    assign pc_inc       = pc_q + XLEN'(PC_STEP);
    assign off_shifted  = pc_offset << OFF_SHIFT;
    assign br_target    = pc_inc + off_shifted;
    assign ras_nonempty = (ras_cnt != '0);
    assign is_jreg      = (sel == PC_SEL_JREG);

    // A stalled cycle must leave the stack and its flags untouched.
    assign ras_push    = !stall && call;
    assign ras_pop     = !stall && ret && is_jreg && ras_nonempty;
    assign ras_unf_req = !stall && ret && !(is_jreg && ras_nonempty);

    // Next-PC select; a return with live stack entries uses the predicted target.
    always_comb begin
        pc_next = pc_inc;
        unique case (sel)
            PC_SEL_SEQ:    pc_next = pc_inc;
            PC_SEL_BRANCH: pc_next = branch_taken ? br_target : pc_inc;
            PC_SEL_JUMP:   pc_next = pc_jmp;
            PC_SEL_JREG:   pc_next = (ret && ras_nonempty) ? ras_top : pc_jr;
        endcase
    end

    // Hold the PC while stalled.
    always_comb begin
        pc_d = stall ? pc_q : pc_next;
    end

    // PC register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q <= RESET_VEC;
        end else begin
            pc_q <= pc_d;
        end
    end

    pc_ras #(
        .XLEN      (XLEN),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (ras_push),
        .pop       (ras_pop),
        .unf_req   (ras_unf_req),
        .push_data (pc_inc),
        .top       (ras_top),
        .count     (ras_cnt),
        .ovf       (err_ovf),
        .unf       (err_unf)
    );

    assign pc           = pc_q;
    assign ras_count    = ras_cnt;
    assign ras_mismatch = ret && is_jreg && ras_nonempty && (ras_top != pc_jr);

endmodule

// File: doc/pc_ctrl.md
Name: pc_ctrl

Overview:
Parametrised program-counter unit for the MIPS core. It is the successor to the fixed 32-bit word-addressed PC.
- Configurable width, step (word or byte addressing), offset shift and reset vector.
- Adds stall hold, a register-jump path, and a small return-address stack (RAS) for call/return with sticky overflow/underflow flags.
- Sits at the head of the fetch path: drives instruction-memory address; receives select/target info from control and datapath.

Parameters:
XLEN, 32, width of PC and all address/offset ports
PC_STEP, 1, sequential increment (1 = word addressed, 4 = byte addressed)
OFF_SHIFT, 0, left shift applied to pc_offset (0 word, 2 byte)
RESET_VEC, 32'h0000_0000, PC value loaded on reset
RAS_DEPTH, 4, return-address stack entries (power of two, >= 2)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
stall  in  1  1 = hold PC and RAS this cycle
pc_sel  in  2  pc_sel_e: SEQ=0, BRANCH=1, JUMP=2, JREG=3
branch_taken  in  1  branch condition result; used only when pc_sel=BRANCH
pc_offset  in  XLEN  sign-extended branch offset
pc_jmp  in  XLEN  absolute jump target
pc_jr  in  XLEN  register-jump target (rs value)
call  in  1  push link address (pc+PC_STEP) onto RAS
ret  in  1  JREG is a return; target taken from RAS top when non-empty
pc  out  XLEN  current PC (registered)
pc_next  out  XLEN  combinational next-PC value
ras_count  out  $clog2(RAS_DEPTH)+1  valid RAS entries
ras_mismatch  out  1  combinational: ret & pc_sel=JREG & RAS non-empty & top != pc_jr
err_ovf  out  1  sticky: push while full
err_unf  out  1  sticky: ret while empty, or ret with pc_sel != JREG

Behaviour:
- Reset (rst=0, async): pc=RESET_VEC, RAS pointer=0, ras_count=0, err_ovf=0, err_unf=0. RAS entry contents are don't-care. On release, first rising edge updates pc normally.
- pc_inc = pc + PC_STEP, modulo 2^XLEN. No carry out; wrap from 2^XLEN-PC_STEP to 0 is legal.
- Next-PC mux (pc_next):
  - SEQ: pc_inc
  - BRANCH: branch_taken ? pc_inc + (pc_offset << OFF_SHIFT) : pc_inc
  - JUMP: pc_jmp
  - JREG: (ret & ras_count!=0) ? RAS top : pc_jr
- All arithmetic is XLEN wide and truncated; the shifted offset is added as two's complement.
- Rising edge with stall=0: pc <= pc_next; RAS updates as below.
- Rising edge with stall=1: pc, RAS, ras_count and error flags all hold. call/ret are ignored. pc_next still shows the would-be value.
- RAS is a circular LIFO: top = entry[ptr-1].
  - push only: entry[ptr] <= pc_inc; ptr++; count = min(count+1, RAS_DEPTH).
  - push when full: overwrites the oldest entry (circular); count stays RAS_DEPTH; err_ovf <= 1.
  - pop only (ret & JREG & count!=0): ptr--; count--.
  - ret & JREG & count==0: target = pc_jr; ptr/count unchanged; err_unf <= 1.
  - ret with pc_sel != JREG: no pop; err_unf <= 1; mux follows pc_sel.
  - call & valid pop in the same cycle: top entry replaced by pc_inc; ptr and count unchanged; target = old top.
- Error flags clear only on reset.
- ras_mismatch is informational only; the next PC is still the RAS top.
- Latency: pc_next is combinational; pc is one cycle later. No internal pipeline.

Decomposition:
- pc_pkg: pc_sel_e enum (2-bit) and the SEQ/BRANCH/JUMP/JREG encodings, shared with the control unit.
- Sub-module pc_ras (parameters XLEN, RAS_DEPTH):
  - ports: push, pop, push_data, top, count, ovf, unf_req.
  - owns the pointer, storage and counters.
- pc_ctrl holds the PC register, increment/offset adders and next-PC mux.

Test Plan:
- Reset: rst=0 mid-run with pc=0x40 -> pc=0x0 immediately (async), ras_count=0, flags 0. Release + 3 SEQ edges -> pc=1,2,3 (PC_STEP=1).
- Branch: pc=0x10, BRANCH, branch_taken=1, pc_offset=-3 -> pc=0x0E. Same with taken=0 -> 0x11. With PC_STEP=4, OFF_SHIFT=2, pc=0x100, offset=2 -> 0x10C.
- Stall: pc=0x20, JUMP pc_jmp=0x80, stall=1 for 2 cycles -> pc stays 0x20 and no push even with call=1. stall=0 -> pc=0x80.
- Call/return: call+JUMP at pc=0x05 (target 0x50), then ret+JREG with pc_jr=0x99 -> pc=0x06, ras_mismatch=1 during the ret cycle, ras_count returns 1 -> 0.
- Overflow/underflow: RAS_DEPTH=4, 5 calls from pc=1,2,3,4,5 -> count=4, err_ovf=1. 4 rets -> targets 6,5,4,3. 5th ret with pc_jr=0x77 -> pc=0x77, err_unf=1.
- Wrap and simultaneous: pc=0xFFFF_FFFF, SEQ -> 0x0. call+ret+JREG with top=0x30 at pc=0x40 -> pc=0x30, top becomes 0x41, count unchanged.
